sockit_spi_que: RTL and testbench
=================================

# sockit_spi_que

Single-clock command/data queue that sits directly upstream of the SPI clock-domain-crossing token stage, on its local-bus side. It accepts words from the register interface with a valid/ready handshake and stores them in a ring buffer of 2**AW entries. It presents the head word to the crossing stage through a req/grt pulse handshake: one word is consumed per cycle with req and grt both high. It gives the crossing stage a stable payload to hold while a token travels to the SPI serializer domain.

## Interface
- DW, 32: data word width, DW >= 1.
- AW, 2: address width; memory depth 2**AW, AW >= 1.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous queue clear; priority below rst, above all transfers.
- bus_vld  input  1  bus word valid.
- bus_dat  input  DW  bus word.
- bus_rdy  output  1  queue can accept a word.
- cdc_req  output  1  head word available, driven to the crossing stage req input.
- cdc_grt  input  1  grant from the crossing stage.
- cdc_dat  output  DW  head word; stable while cdc_req is high and no transfer occurs.
- cnt  output  AW+1  number of words held, including the output register when present.

## Operation
- Write transfer: bus_vld & bus_rdy at a rising edge. The word is written to mem[wpt] and wpt increments modulo 2**AW.
- Read transfer: cdc_req & cdc_grt at a rising edge. The head is retired and rpt increments modulo 2**AW.
- Memory occupancy counter: mcnt, AW+1 bits.
  - A simultaneous write and read leaves mcnt unchanged.
  - A write alone increments it; a read alone decrements it.
- Full and empty:
  - bus_rdy = (mcnt != 2**AW), registered-state decode with no combinational path from bus_vld.
  - cdc_req high when the head is valid; no combinational path from cdc_grt.
- Full with a simultaneous read: bus_rdy is low, so no write occurs that cycle. There is no pass-through at full.
- Empty with bus_vld: the word is written and is not visible on cdc_req in the same cycle.
- flush: clears wpt, rpt, mcnt and the output-valid flag. A write or read in the same cycle is discarded. Memory contents are unchanged.
- rst: same effect as flush.
- Reset values:
  - bus_rdy = 1, cdc_req = 0, cnt = 0.
  - cdc_dat = mem[0] content, undefined after power-up; 0 when the output register is compiled in.
- The 2**AW wrap of the pointers is transparent. The sequence order of words is preserved exactly.

## Timing
- Write to cdc_req latency:
  - Without the output register: 1 cycle. A word written at edge N gives cdc_req high after edge N.
  - With the output register: 2 cycles.
- Read throughput: 1 word per cycle while cdc_grt is held high and data is available.
- bus_rdy falls in the cycle after the write that fills the memory. It rises in the cycle after the first read from full.
- cnt updates on the same edge as the transfer that changes it.

## Configuration
- Macro: SOCKIT_SPI_QUE_OREG_EN.
- Defined: a registered output stage (oreg, ovld) is added in front of cdc_dat/cdc_req.
  - cdc_dat = oreg and cdc_req = ovld.
  - oreg loads mem[rpt] and rpt increments when (!ovld | cdc_grt) and mcnt != 0.
  - If mcnt = 0 at a read transfer, ovld clears.
  - Capacity is 2**AW + 1; cnt = mcnt + ovld.
  - oreg resets to 0.
- Undefined:
  - cdc_dat = mem[rpt], combinational read.
  - cdc_req = (mcnt != 0).
  - Capacity is 2**AW; cnt = mcnt.

## Test plan
- Reset then idle: rst high 2 cycles -> bus_rdy=1, cdc_req=0, cnt=0. Check through 5 idle cycles.
- Fill with DW=32, AW=2 and OREG undefined:
  - Write 0x11,0x22,0x33,0x44 with cdc_grt=0 -> cnt=4, bus_rdy=0 after the 4th edge, cdc_dat=0x11.
  - A 5th bus_vld is held off.
- Drain: from the full state, hold cdc_grt=1 for 4 cycles -> cdc_dat sequence 0x11,0x22,0x33,0x44. Then cdc_req=0, cnt=0, bus_rdy=1.
- Streaming wrap: bus_vld=1 and cdc_grt=1 continuously for 20 words 0..19 -> order preserved across 5 pointer wraps, and cnt stays at or below 2 after the first word.
- Flush mid-operation: with 3 words held, assert flush together with bus_vld and cdc_grt -> next cycle cnt=0, cdc_req=0. The next written word 0xAB appears as the head.
- OREG defined:
  - Write 0x55 at edge N -> cdc_req rises after edge N+1.
  - Fill with cdc_grt=0 -> capacity 5, bus_rdy=0 with cnt=5.
  - Drain order is preserved.

Source files
------------

// File: rtl/sockit_spi_que.sv
// Ring-buffer queue feeding the SPI clock-domain-crossing token stage (valid/ready in, req/grt out).
// Define SOCKIT_SPI_QUE_OREG_EN to add a registered output stage in front of cdc_dat/cdc_req.
module sockit_spi_que #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          bus_vld,
  input  logic [DW-1:0] bus_dat,
  output logic          bus_rdy,
  output logic          cdc_req,
  input  logic          cdc_grt,
  output logic [DW-1:0] cdc_dat,
  output logic [AW:0]   cnt
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wpt_q, wpt_d;
  logic [AW-1:0] rpt_q, rpt_d;
  logic [AW:0]   mcnt_q, mcnt_d;
  logic          wr;
  logic          rd_mem;
  logic          mem_nempty;

  // Full/empty decode from registered state only, so no input reaches bus_rdy/cdc_req.
  assign bus_rdy    = (mcnt_q != FULL);
  assign mem_nempty = (mcnt_q != '0);
  assign wr         = bus_vld & bus_rdy;

`ifdef SOCKIT_SPI_QUE_OREG_EN
  logic          ovld_q, ovld_d;
  logic [DW-1:0] oreg_q, oreg_d;

  // Refill the output register whenever it is empty or being consumed.
  assign rd_mem = (!ovld_q | cdc_grt) & mem_nempty;

  always_comb begin
    ovld_d = ovld_q;
    oreg_d = oreg_q;
    if (flush) begin
      ovld_d = 1'b0;
    end else if (rd_mem) begin
      ovld_d = 1'b1;
      oreg_d = mem_q[rpt_q];
    end else if (cdc_grt) begin
      ovld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovld_q <= 1'b0;
      oreg_q <= '0;
    end else begin
      ovld_q <= ovld_d;
      oreg_q <= oreg_d;
    end
  end

  assign cdc_req = ovld_q;
  assign cdc_dat = oreg_q;
  assign cnt     = mcnt_q + {{AW{1'b0}}, ovld_q};
`else
  assign rd_mem  = mem_nempty & cdc_grt;
  assign cdc_req = mem_nempty;
  assign cdc_dat = mem_q[rpt_q];
  assign cnt     = mcnt_q;
`endif

  always_comb begin
    wpt_d  = wpt_q;
    rpt_d  = rpt_q;
    mcnt_d = mcnt_q;
    if (flush) begin
      wpt_d  = '0;
      rpt_d  = '0;
      mcnt_d = '0;
    end else begin
      if (wr)     wpt_d = wpt_q + 1'b1;
      if (rd_mem) rpt_d = rpt_q + 1'b1;
      case ({wr, rd_mem})
        2'b10:   mcnt_d = mcnt_q + 1'b1;
        2'b01:   mcnt_d = mcnt_q - 1'b1;
        default: mcnt_d = mcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wpt_q  <= '0;
      rpt_q  <= '0;
      mcnt_q <= '0;
    end else begin
      wpt_q  <= wpt_d;
      rpt_q  <= rpt_d;
      mcnt_q <= mcnt_d;
    end
  end

  // Storage has no reset; a write coinciding with flush or rst is dropped.
  always_ff @(posedge clk) begin
    if (wr && !flush && !rst) begin
      mem_q[wpt_q] <= bus_dat;
    end
  end

endmodule

// File: tb/tb_sockit_spi_que.sv
// Directed, table-driven bench for sockit_spi_que (DW=32, AW=2), both output-stage builds.
module tb_sockit_spi_que;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        bus_vld;
  logic [31:0] bus_dat;
  logic        bus_rdy;
  logic        cdc_req;
  logic        cdc_grt;
  logic [31:0] cdc_dat;
  logic [2:0]  cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sockit_spi_que #(.DW(32), .AW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bus_vld (bus_vld),
    .bus_dat (bus_dat),
    .bus_rdy (bus_rdy),
    .cdc_req (cdc_req),
    .cdc_grt (cdc_grt),
    .cdc_dat (cdc_dat),
    .cnt     (cnt)
  );

  always #5 clk = ~clk;

  // Expected outputs describe the state visible while the row's inputs are applied.
  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        grt;
    logic        fl;
    logic        rdy;
    logic        req;
    logic [2:0]  ecnt;
    logic        chk;
    logic [31:0] edat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic vld, logic [31:0] dat, logic grt, logic fl,
                              logic rdy, logic req, logic [2:0] ecnt,
                              logic chk, logic [31:0] edat);
    vec_t v;
    v.vld = vld; v.dat = dat; v.grt = grt; v.fl = fl;
    v.rdy = rdy; v.req = req; v.ecnt = ecnt; v.chk = chk; v.edat = edat;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      bus_vld = tbl[i].vld;
      bus_dat = tbl[i].dat;
      cdc_grt = tbl[i].grt;
      flush   = tbl[i].fl;
      #1;
      $display("row %0d: vld=%0b dat=%0h grt=%0b flush=%0b -> rdy=%0b req=%0b cnt=%0d dat=%0h",
               i, bus_vld, bus_dat, cdc_grt, flush, bus_rdy, cdc_req, cnt, cdc_dat);
      check($sformatf("row%0d.bus_rdy", i), {31'b0, bus_rdy}, {31'b0, tbl[i].rdy});
      check($sformatf("row%0d.cdc_req", i), {31'b0, cdc_req}, {31'b0, tbl[i].req});
      check($sformatf("row%0d.cnt", i), {29'b0, cnt}, {29'b0, tbl[i].ecnt});
      if (tbl[i].chk) check($sformatf("row%0d.cdc_dat", i), cdc_dat, tbl[i].edat);
    end
    @(negedge clk);
    bus_vld = 1'b0;
    cdc_grt = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; bus_vld = 1'b0; bus_dat = '0; cdc_grt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifdef SOCKIT_SPI_QUE_OREG_EN
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 0, 1, 32'h0);
    add(1, 32'h55, 0, 0, 1, 0, 0, 1, 32'h0);
    add(0, 0,      0, 0, 1, 0, 1, 1, 32'h0);
    add(1, 32'h66, 0, 0, 1, 1, 1, 1, 32'h55);
    add(1, 32'h77, 0, 0, 1, 1, 2, 1, 32'h55);
    add(1, 32'h88, 0, 0, 1, 1, 3, 1, 32'h55);
    add(1, 32'h99, 0, 0, 1, 1, 4, 1, 32'h55);
    add(1, 32'hAA, 0, 0, 0, 1, 5, 1, 32'h55);
    add(0, 0, 1, 0, 0, 1, 5, 1, 32'h55);
    add(0, 0, 1, 0, 1, 1, 4, 1, 32'h66);
    add(0, 0, 1, 0, 1, 1, 3, 1, 32'h77);
    add(0, 0, 1, 0, 1, 1, 2, 1, 32'h88);
    add(0, 0, 1, 0, 1, 1, 1, 1, 32'h99);
    add(0, 0, 0, 0, 1, 0, 0, 1, 32'h99);
    run_table();
`else
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // fill, then a 5th word is held off
    add(1, 32'h11, 0, 0, 1, 0, 0, 0, 0);
    add(1, 32'h22, 0, 0, 1, 1, 1, 1, 32'h11);
    add(1, 32'h33, 0, 0, 1, 1, 2, 1, 32'h11);
    add(1, 32'h44, 0, 0, 1, 1, 3, 1, 32'h11);
    add(1, 32'h55, 0, 0, 0, 1, 4, 1, 32'h11);
    add(1, 32'h55, 0, 0, 0, 1, 4, 1, 32'h11);
    // drain
    add(0, 0, 1, 0, 0, 1, 4, 1, 32'h11);
    add(0, 0, 1, 0, 1, 1, 3, 1, 32'h22);
    add(0, 0, 1, 0, 1, 1, 2, 1, 32'h33);
    add(0, 0, 1, 0, 1, 1, 1, 1, 32'h44);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // full with simultaneous read: no pass-through write
    add(1, 32'h1,  0, 0, 1, 0, 0, 0, 0);
    add(1, 32'h2,  0, 0, 1, 1, 1, 1, 32'h1);
    add(1, 32'h3,  0, 0, 1, 1, 2, 1, 32'h1);
    add(1, 32'h4,  0, 0, 1, 1, 3, 1, 32'h1);
    add(1, 32'h99, 1, 0, 0, 1, 4, 1, 32'h1);
    add(0, 0, 1, 0, 1, 1, 3, 1, 32'h2);
    add(0, 0, 1, 0, 1, 1, 2, 1, 32'h3);
    add(0, 0, 1, 0, 1, 1, 1, 1, 32'h4);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    // flush with concurrent write and read
    add(1, 32'hA1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 32'hA2, 0, 0, 1, 1, 1, 1, 32'hA1);
    add(1, 32'hA3, 0, 0, 1, 1, 2, 1, 32'hA1);
    add(1, 32'hEE, 1, 1, 1, 1, 3, 1, 32'hA1);
    add(1, 32'hAB, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 1, 1, 32'hAB);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    run_table();

    // streaming across several pointer wraps
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus_vld = 1'b1; bus_dat = 32'(i); cdc_grt = 1'b1;
      #1;
      $display("stream %0d: req=%0b cnt=%0d dat=%0h", i, cdc_req, cnt, cdc_dat);
      if (i == 0) begin
        check("stream0.cdc_req", {31'b0, cdc_req}, 32'd0);
      end else begin
        check($sformatf("stream%0d.cdc_dat", i), cdc_dat, 32'(i - 1));
        check($sformatf("stream%0d.cnt_le2", i), {31'b0, (cnt <= 3'd2)}, 32'd1);
      end
    end
    @(negedge clk);
    bus_vld = 1'b0;
    #1;
    check("stream_tail.cdc_dat", cdc_dat, 32'd19);
    @(negedge clk);
    cdc_grt = 1'b0;
    #1;
    check("stream_end.cnt", {29'b0, cnt}, 32'd0);
    check("stream_end.cdc_req", {31'b0, cdc_req}, 32'd0);
`endif

    // reset while holding data and with a write pending
    @(negedge clk); bus_vld = 1'b1; bus_dat = 32'h1;
    @(negedge clk); bus_dat = 32'h2;
    @(negedge clk); rst = 1'b1; bus_dat = 32'h3;
    @(negedge clk); rst = 1'b0; bus_vld = 1'b0;
    #1;
    $display("post-reset: rdy=%0b req=%0b cnt=%0d", bus_rdy, cdc_req, cnt);
    check("rst.cnt", {29'b0, cnt}, 32'd0);
    check("rst.cdc_req", {31'b0, cdc_req}, 32'd0);
    check("rst.bus_rdy", {31'b0, bus_rdy}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
